// File: rtl/onchip_memory_stream_reader.sv
// Avalon-MM read master for a fixed-latency on-chip RAM. Fetched words are streamed out
// in order through a first-word-fall-through FIFO, and reads are issued against FIFO credit.
module onchip_memory_stream_reader #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned WC_W  = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]              state, state_nxt;
  logic [ADDR_W-1:0]       next_addr;
  logic [WC_W-1:0]         remaining;
  logic [CNT_W-1:0]        in_flight, in_flight_nxt;
  logic [CNT_W-1:0]        fifo_count, fifo_count_nxt;
  logic [READ_LATENCY-1:0] tag;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic                    push, pop, credit_ok, issue, load, flush;

  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign src_data       = fifo_mem[rd_ptr];

  assign push = tag[READ_LATENCY-1];
  assign pop  = src_valid & src_ready;

  // A read may only go out if its word is guaranteed a FIFO slot on return.
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(in_flight) + SUM_W'(1)) <= SUM_W'(FIFO_DEPTH);

  assign in_flight_nxt  = in_flight + CNT_W'(issue) - CNT_W'(push);
  assign fifo_count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    load      = 1'b0;
    flush     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (word_count == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_nxt = S_FLUSH;
        end else if (remaining != '0 && credit_ok) begin
          issue = 1'b1;
          if (remaining == WC_W'(1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Looking at the post-pop count lets done follow the last pop by one cycle.
        if (abort)                                       state_nxt = S_FLUSH;
        else if (in_flight == '0 && fifo_count_nxt == '0) state_nxt = S_FIN;
      end
      S_FLUSH: begin
        if (in_flight == '0) begin
          flush     = 1'b1;
          state_nxt = S_FIN;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue side: address/count bookkeeping and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_addr      <= '0;
      remaining      <= '0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      in_flight      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      avm_chipselect <= issue;
      in_flight      <= in_flight_nxt;
      busy           <= (state_nxt != S_IDLE);
      done           <= (state_nxt == S_FIN);
      if (load) begin
        next_addr <= base_addr;
        remaining <= word_count;
      end else if (issue) begin
        avm_address <= next_addr;
        next_addr   <= next_addr + ADDR_W'(1);
        remaining   <= remaining - WC_W'(1);
      end
    end
  end

  // Return tags line up with readdata; clearing them on reset drops stale returns.
  if (READ_LATENCY > 1) begin : g_tag_shift
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tag <= '0;
      else          tag <= {tag[READ_LATENCY-2:0], avm_chipselect};
    end
  end else begin : g_tag_single
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tag <= '0;
      else          tag <= avm_chipselect;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      src_valid  <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      src_valid  <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= avm_readdata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count_nxt;
      src_valid  <= (fifo_count_nxt != '0);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule
